bldc_commutation_sequencer: RTL and testbench
=============================================

# bldc_commutation_sequencer

Six-step BLDC commutation controller. It sits between the hall sensor inputs and the half-bridge gate pins, and sequences the six gate enables from the filtered hall sector and the requested direction. Every pattern change passes through an all-off dead-time window. The block also handles driver-fault shutdown, invalid-hall detection and stall detection. The PWM generator output is gated onto the high-side switches only.

## Interface
Parameters:
- DEADTIME, 64: clk cycles with all gates off between any two drive patterns (1..255).
- HALL_FILTER, 4: consecutive identical synchronized hall samples required to accept a new hall code (1..15).
- STALL_CYCLES, 16_000_000: cycles in DRIVE without an accepted sector change before a stall is declared (1 s at 16 MHz).

Ports:
- clk  in  1  system clock, 16 MHz.
- reset  in  1  synchronous, active-high.
- hall  in  3  {hall1, hall2, hall3}, asynchronous, pulled up.
- dir  in  1  1 = forward, 0 = reverse.
- enable  in  1  drive request; low clears sticky flags.
- fault_n  in  1  gate-driver fault, active low, asynchronous.
- pwm_in  in  1  PWM waveform from the PWM generator.
- inha, inla, inhb, inlb, inhc, inlc  out  1 each  gate drive, high/low side per phase.
- sector  out  3  current accepted sector, 0..5; 7 = invalid.
- step_pulse  out  1  one-cycle pulse per accepted sector change.
- hall_error  out  1  sticky; invalid hall code seen while driving.
- stalled  out  1  sticky; stall detected.
- fault_latched  out  1  sticky; fault_n seen low.

## Operation
- Hall path: 2-FF synchronizer, then filter. A code is accepted after HALL_FILTER consecutive equal samples.
- Hall code to sector: 101→0, 100→1, 110→2, 010→3, 011→4, 001→5. 000 and 111 are invalid (sector = 7).
- Forward patterns (high, low): 0:(C,B), 1:(A,B), 2:(A,C), 3:(B,C), 4:(B,A), 5:(C,A).
- Reverse patterns (high, low): 0:(B,C), 1:(B,A), 2:(C,A), 3:(C,B), 4:(A,B), 5:(A,C).
- Gate registers gh[a,b,c] and gl[a,b,c] are set only in DRIVE.
- Output equations: inhX = ghX & pwm_in & fault_n_sync. inlX = glX & fault_n_sync.
- FSM states: IDLE, DEAD, DRIVE, FAULT. All gate registers are 0 outside DRIVE.
- IDLE: when enable & fault_n & sector≠7, go to DEAD and load the counter with DEADTIME.
- DEAD: decrement the counter. At 1, go to DRIVE, latching the pattern from the current sector and dir. A sector or dir change during DEAD does not restart the counter. If the sector is invalid at exit, go to IDLE.
- DRIVE, accepted sector change or dir change: go to DEAD and reload the counter.
- DRIVE, enable low: go to IDLE.
- DRIVE, sector = 7: set hall_error, go to IDLE.
- DRIVE, stall counter reaches STALL_CYCLES: set stalled, go to FAULT.
- Stall counter: clears on every step_pulse and whenever the state is not DRIVE.
- Any state, fault_n_sync low: set fault_latched, go to FAULT.
- FAULT: leave to IDLE only when fault_n_sync is high and enable is low.
- Sticky flags clear on reset, or on any cycle with enable low and fault_n_sync high.
- Priority, highest first: reset, fault, enable low, invalid hall, stall, pattern change.
- Counters: dead-time counter 8 bits. Stall counter sized for STALL_CYCLES, saturating, no wrap.

## Timing
- Reset values: state IDLE, all gate outputs 0, sector 7, step_pulse 0, all sticky flags 0.
- Hall edge to sector update: 2 + HALL_FILTER cycles. step_pulse is asserted in the same cycle sector updates.
- Sector update to gates off: 1 cycle (DRIVE→DEAD).
- Gates off to new pattern: DEADTIME cycles.
- fault_n falling to outputs low: 2 cycles (sync). Gate registers clear 1 cycle later.
- pwm_in to inhX: combinational, no register.
- High and low side of the same phase are never both 1 in any cycle. Consecutive patterns are always separated by ≥ DEADTIME all-zero cycles.

## Test plan
- Reset, then hall=101, dir=1, enable=1, pwm_in=1 → sector=0 after 6 cycles. All gates 0 for 64 cycles. Then inhc=1 and inlb=1, all others 0.
- Step hall forward through 101,100,110,010,011,001 with 2000 cycles per step → six step_pulses. Each pattern matches the forward table. Exactly 64 all-off cycles precede each pattern. hall_error=0.
- Toggle dir mid-DRIVE in sector 2 → 64 all-off cycles, then inhc=1 and inla=1.
- Hall glitch to 100 for 3 cycles during sector 0 → filtered out, no step_pulse, gates unchanged. Hold hall=111 for 10 cycles → hall_error=1, state IDLE, gates 0.
- fault_n low 1 cycle while driving → outputs 0 within 2 cycles, fault_latched=1. Gates stay 0 after fault_n returns while enable=1. Drop enable, then raise it → flags clear, DEAD then DRIVE resumes.
- With STALL_CYCLES=1000, hold the hall constant while driving → stalled=1 and gates 0 at cycle 1000 after DRIVE entry. Cleared by enable low.

Source files
------------

// File: rtl/bldc_commutation_sequencer_if.sv
// rtl/bldc_commutation_sequencer_if.sv - hall/control inputs and gate/status outputs of the commutation sequencer
interface bldc_commutation_sequencer_if;
  logic [2:0] hall;
  logic       dir;
  logic       enable;
  logic       fault_n;
  logic       pwm_in;
  logic       inha, inla, inhb, inlb, inhc, inlc;
  logic [2:0] sector;
  logic       step_pulse;
  logic       hall_error;
  logic       stalled;
  logic       fault_latched;

  modport master (
    output hall, dir, enable, fault_n, pwm_in,
    input  inha, inla, inhb, inlb, inhc, inlc,
    input  sector, step_pulse, hall_error, stalled, fault_latched
  );

  modport slave (
    input  hall, dir, enable, fault_n, pwm_in,
    output inha, inla, inhb, inlb, inhc, inlc,
    output sector, step_pulse, hall_error, stalled, fault_latched
  );
endinterface

// File: rtl/bldc_commutation_sequencer.sv
// rtl/bldc_commutation_sequencer.sv - six-step BLDC commutation with hall filter, dead time, fault and stall handling
module bldc_commutation_sequencer #(
  parameter int DEADTIME     = 64,
  parameter int HALL_FILTER  = 4,
  parameter int STALL_CYCLES = 16_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  bldc_commutation_sequencer_if.slave  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DEAD  = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [7:0]         DEAD_LOAD  = 8'(DEADTIME);
  localparam logic [3:0]         FILT_N     = 4'(HALL_FILTER);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_CYCLES);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);

  logic [2:0]         hall_s1, hall_s2, hall_last;
  logic [3:0]         filt_cnt, filt_next;
  logic               fault_s1, fault_n_sync;
  logic [2:0]         sector, code_sector;
  logic               accept, step_pulse;
  logic [1:0]         state, state_next;
  logic [7:0]         dead_cnt, dead_next;
  logic [STALL_W-1:0] stall_cnt;
  logic [2:0]         gh, gl;
  logic               dir_latched, load_gates;
  logic               set_hall_err, set_stall;
  logic               hall_error, stalled, fault_latched;

  function automatic logic [2:0] decode(input logic [2:0] code);
    logic [2:0] s;
    case (code)
      3'b101:  s = 3'd0;
      3'b100:  s = 3'd1;
      3'b110:  s = 3'd2;
      3'b010:  s = 3'd3;
      3'b011:  s = 3'd4;
      3'b001:  s = 3'd5;
      default: s = 3'd7;
    endcase
    return s;
  endfunction

  // Bit 0 = phase A. Reverse drive is the forward pattern with high and low roles swapped.
  function automatic logic [5:0] pattern(input logic [2:0] s, input logic d);
    logic [2:0] hi, lo;
    case (s)
      3'd0:    begin hi = 3'b100; lo = 3'b010; end
      3'd1:    begin hi = 3'b001; lo = 3'b010; end
      3'd2:    begin hi = 3'b001; lo = 3'b100; end
      3'd3:    begin hi = 3'b010; lo = 3'b100; end
      3'd4:    begin hi = 3'b010; lo = 3'b001; end
      default: begin hi = 3'b100; lo = 3'b001; end
    endcase
    return d ? {hi, lo} : {lo, hi};
  endfunction

  // filt_next counts consecutive equal synchronized samples, including the current one.
  always_comb begin
    filt_next = filt_cnt;
    if (hall_s2 != hall_last) filt_next = 4'd1;
    else if (filt_cnt < FILT_N) filt_next = filt_cnt + 4'd1;
  end

  assign code_sector = decode(hall_s2);
  assign accept      = (filt_next >= FILT_N) && (code_sector != sector);

  always_comb begin
    state_next   = state;
    dead_next    = dead_cnt;
    load_gates   = 1'b0;
    set_hall_err = 1'b0;
    set_stall    = 1'b0;
    if (!fault_n_sync) begin
      state_next = FAULT;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable && sector != 3'd7) begin
            state_next = DEAD;
            dead_next  = DEAD_LOAD;
          end
        end
        DEAD: begin
          if (!bus.enable) begin
            state_next = IDLE;
          end else if (dead_cnt <= 8'd1) begin
            state_next = (sector == 3'd7) ? IDLE : DRIVE;
            load_gates = (sector != 3'd7);
          end else begin
            dead_next = dead_cnt - 8'd1;
          end
        end
        DRIVE: begin
          if (!bus.enable) begin
            state_next = IDLE;
          end else if (sector == 3'd7) begin
            state_next   = IDLE;
            set_hall_err = 1'b1;
          end else if (stall_cnt >= STALL_LAST) begin
            state_next = FAULT;
            set_stall  = 1'b1;
          end else if (step_pulse || bus.dir != dir_latched) begin
            state_next = DEAD;
            dead_next  = DEAD_LOAD;
          end
        end
        default: begin
          if (!bus.enable) state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hall_s1       <= 3'b111;
      hall_s2       <= 3'b111;
      hall_last     <= 3'b111;
      filt_cnt      <= 4'd0;
      fault_s1      <= 1'b1;
      fault_n_sync  <= 1'b1;
      sector        <= 3'd7;
      step_pulse    <= 1'b0;
      state         <= IDLE;
      dead_cnt      <= 8'd0;
      stall_cnt     <= '0;
      gh            <= 3'b000;
      gl            <= 3'b000;
      dir_latched   <= 1'b0;
      hall_error    <= 1'b0;
      stalled       <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      hall_s1      <= bus.hall;
      hall_s2      <= hall_s1;
      hall_last    <= hall_s2;
      filt_cnt     <= filt_next;
      fault_s1     <= bus.fault_n;
      fault_n_sync <= fault_s1;
      step_pulse   <= accept;
      if (accept) sector <= code_sector;

      state    <= state_next;
      dead_cnt <= dead_next;
      if (load_gates) begin
        {gh, gl}    <= pattern(sector, bus.dir);
        dir_latched <= bus.dir;
      end else if (state_next != DRIVE) begin
        gh <= 3'b000;
        gl <= 3'b000;
      end

      if (state != DRIVE || step_pulse) stall_cnt <= '0;
      else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + STALL_ONE;

      if (!bus.enable && fault_n_sync) begin
        hall_error    <= 1'b0;
        stalled       <= 1'b0;
        fault_latched <= 1'b0;
      end else begin
        if (!fault_n_sync) fault_latched <= 1'b1;
        if (set_hall_err)  hall_error    <= 1'b1;
        if (set_stall)     stalled       <= 1'b1;
      end
    end
  end

  assign bus.inha          = gh[0] & bus.pwm_in & fault_n_sync;
  assign bus.inhb          = gh[1] & bus.pwm_in & fault_n_sync;
  assign bus.inhc          = gh[2] & bus.pwm_in & fault_n_sync;
  assign bus.inla          = gl[0] & fault_n_sync;
  assign bus.inlb          = gl[1] & fault_n_sync;
  assign bus.inlc          = gl[2] & fault_n_sync;
  assign bus.sector        = sector;
  assign bus.step_pulse    = step_pulse;
  assign bus.hall_error    = hall_error;
  assign bus.stalled       = stalled;
  assign bus.fault_latched = fault_latched;
endmodule

// File: tb/tb_bldc_commutation_sequencer.sv
// tb/tb_bldc_commutation_sequencer.sv - randomized scenario bench for bldc_commutation_sequencer
module tb_bldc_commutation_sequencer;
  localparam int DT = 64;
  localparam int HF = 4;
  localparam int SC = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bldc_commutation_sequencer_if bus ();

  bldc_commutation_sequencer #(
    .DEADTIME(DT), .HALL_FILTER(HF), .STALL_CYCLES(SC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int zero_run = 0;
  logic [5:0] last_pat = '0;
  bit have_last = 0;
  bit track_gap = 0;
  int cur_s = 0;
  bit cur_d = 1;
  string fwd_tab = "CBABACBCBACA";
  string rev_tab = "BCBACACBABAC";

  function automatic logic [2:0] hall_of(input int s);
    logic [2:0] tab [6];
    tab = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    return tab[s];
  endfunction

  function automatic logic [2:0] exp_sector(input logic [2:0] code);
    for (int i = 0; i < 6; i++) if (hall_of(i) == code) return 3'(i);
    return 3'd7;
  endfunction

  // Vector order {inha, inhb, inhc, inla, inlb, inlc}; tables list (high, low) phase letters per sector.
  function automatic logic [5:0] exp_gates(input int s, input bit d);
    string t;
    int hi, lo;
    logic [5:0] g;
    t = d ? fwd_tab : rev_tab;
    hi = int'(t.getc(2 * s)) - 65;
    lo = int'(t.getc(2 * s + 1)) - 65;
    g = '0;
    g[5 - hi] = 1'b1;
    g[2 - lo] = 1'b1;
    return g;
  endfunction

  function automatic logic [5:0] cur_gates();
    return {bus.inha, bus.inhb, bus.inhc, bus.inla, bus.inlb, bus.inlc};
  endfunction

  task automatic tick();
    logic [5:0] g;
    @(posedge clk);
    #1;
    g = cur_gates();
    checks++;
    if ((g[5:3] & g[2:0]) != 3'b000) begin
      failures++;
      $display("FAIL shoot_through gates=%b required no phase with both sides on", g);
    end
    if (track_gap) begin
      if (g == 6'b0) zero_run++;
      else begin
        if (have_last && g != last_pat) begin
          checks++;
          if (zero_run < DT) begin
            failures++;
            $display("FAIL dead_gap off_cycles=%0d required>=%0d", zero_run, DT);
          end
        end
        last_pat  = g;
        have_last = 1;
        zero_run  = 0;
      end
    end
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic hall_step(input logic [2:0] code, input string name);
    int n;
    n = 0;
    bus.hall = code;
    do begin tick(); n++; end while (bus.sector !== exp_sector(code) && n < 40);
    checks++;
    if (n != 2 + HF) begin
      failures++;
      $display("FAIL %s_latency cycles=%0d required=%0d", name, n, 2 + HF);
    end
    checks++;
    if (bus.step_pulse !== 1'b1) begin
      failures++;
      $display("FAIL %s_step_pulse got=%b required=1", name, bus.step_pulse);
    end
  endtask

  task automatic wait_pattern(input logic [5:0] exp, input string name);
    int n;
    tick();
    checks++;
    if (cur_gates() !== 6'b0) begin
      failures++;
      $display("FAIL %s_off gates=%b required=000000", name, cur_gates());
    end
    checks++;
    if (bus.step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse_width step_pulse=%b required=0", name, bus.step_pulse);
    end
    n = 0;
    do begin tick(); n++; end while (cur_gates() === 6'b0 && n < 3 * DT);
    checks++;
    if (n != DT) begin
      failures++;
      $display("FAIL %s_deadtime off_cycles=%0d required=%0d", name, n, DT);
    end
    checks++;
    if (cur_gates() !== exp) begin
      failures++;
      $display("FAIL %s_pattern gates=%b required=%b", name, cur_gates(), exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.hall = 3'b101; bus.dir = 1'b1; bus.enable = 1'b1; bus.fault_n = 1'b1; bus.pwm_in = 1'b1;
    hold(3);
    checks++;
    if (bus.sector !== 3'd7 || cur_gates() !== 6'b0 || bus.step_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs sector=%0d gates=%b step=%b required sector=7 gates=0 step=0",
               bus.sector, cur_gates(), bus.step_pulse);
    end
    checks++;
    if ({bus.hall_error, bus.stalled, bus.fault_latched} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags flags=%b required=000", {bus.hall_error, bus.stalled, bus.fault_latched});
    end
    reset = 1'b0;
  endtask

  task automatic test_startup();
    hall_step(3'b101, "startup");
    wait_pattern(exp_gates(0, 1), "startup");
    cur_s = 0; cur_d = 1;
    last_pat = cur_gates(); have_last = 1; zero_run = 0; track_gap = 1;
  endtask

  task automatic test_forward_steps();
    for (int i = 1; i <= 6; i++) begin
      cur_s = i % 6;
      hold($urandom_range(100, 500));
      hall_step(hall_of(cur_s), "fwd_step");
      wait_pattern(exp_gates(cur_s, 1), "fwd_step");
    end
    checks++;
    if (bus.hall_error !== 1'b0) begin
      failures++;
      $display("FAIL fwd_hall_error got=%b required=0", bus.hall_error);
    end
  endtask

  task automatic test_dir_toggle();
    for (int s = 1; s <= 2; s++) begin
      hold($urandom_range(50, 200));
      hall_step(hall_of(s), "to_sector2");
      wait_pattern(exp_gates(s, 1), "to_sector2");
    end
    cur_s = 2;
    hold($urandom_range(20, 200));
    bus.dir = 1'b0; cur_d = 0;
    wait_pattern(exp_gates(2, 0), "dir_toggle_rev");
    hold($urandom_range(20, 200));
    bus.dir = 1'b1; cur_d = 1;
    wait_pattern(exp_gates(2, 1), "dir_toggle_fwd");
  endtask

  task automatic test_pwm();
    logic [5:0] e;
    track_gap = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      bus.pwm_in = 1'($urandom);
      #1;
      e = exp_gates(cur_s, cur_d);
      if (!bus.pwm_in) e[5:3] = 3'b000;
      checks++;
      if (cur_gates() !== e) begin
        failures++;
        $display("FAIL pwm_gating pwm=%b gates=%b required=%b", bus.pwm_in, cur_gates(), e);
      end
    end
    bus.pwm_in = 1'b1;
    tick();
    last_pat = cur_gates(); have_last = 1; zero_run = 0; track_gap = 1;
  endtask

  task automatic test_glitch_and_invalid();
    logic [5:0] e;
    int other;
    e = exp_gates(cur_s, cur_d);
    other = (cur_s + int'($urandom_range(1, 5))) % 6;
    bus.hall = hall_of(other);
    hold($urandom_range(1, HF - 1));
    bus.hall = hall_of(cur_s);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.step_pulse !== 1'b0 || cur_gates() !== e) begin
        failures++;
        $display("FAIL glitch_filtered step=%b gates=%b required step=0 gates=%b", bus.step_pulse, cur_gates(), e);
      end
    end
    bus.hall = 3'b111;
    hold(10);
    checks++;
    if (bus.hall_error !== 1'b1 || cur_gates() !== 6'b0 || bus.sector !== 3'd7) begin
      failures++;
      $display("FAIL invalid_hall err=%b gates=%b sector=%0d required err=1 gates=0 sector=7",
               bus.hall_error, cur_gates(), bus.sector);
    end
    hall_step(hall_of(cur_s), "hall_recover");
    wait_pattern(e, "hall_recover");
    checks++;
    if (bus.hall_error !== 1'b1) begin
      failures++;
      $display("FAIL hall_error_sticky got=%b required=1", bus.hall_error);
    end
    bus.enable = 1'b0;
    tick();
    checks++;
    if (bus.hall_error !== 1'b0 || cur_gates() !== 6'b0) begin
      failures++;
      $display("FAIL hall_error_clear err=%b gates=%b required err=0 gates=0", bus.hall_error, cur_gates());
    end
    bus.enable = 1'b1;
    wait_pattern(e, "enable_resume");
  endtask

  task automatic test_fault();
    logic [5:0] e;
    e = exp_gates(cur_s, cur_d);
    hold($urandom_range(20, 200));
    bus.fault_n = 1'b0;
    tick();
    bus.fault_n = 1'b1;
    checks++;
    if (cur_gates() !== e) begin
      failures++;
      $display("FAIL fault_sync_cycle1 gates=%b required=%b", cur_gates(), e);
    end
    tick();
    checks++;
    if (cur_gates() !== 6'b0) begin
      failures++;
      $display("FAIL fault_outputs_off gates=%b required=000000", cur_gates());
    end
    tick();
    checks++;
    if (bus.fault_latched !== 1'b1) begin
      failures++;
      $display("FAIL fault_latched got=%b required=1", bus.fault_latched);
    end
    hold(100);
    checks++;
    if (cur_gates() !== 6'b0 || bus.fault_latched !== 1'b1) begin
      failures++;
      $display("FAIL fault_hold gates=%b latched=%b required gates=0 latched=1", cur_gates(), bus.fault_latched);
    end
    bus.enable = 1'b0;
    tick();
    checks++;
    if (bus.fault_latched !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear got=%b required=0", bus.fault_latched);
    end
    bus.enable = 1'b1;
    wait_pattern(e, "fault_resume");
  endtask

  task automatic test_random_walk();
    bit d;
    d = 1'($urandom);
    if (d != cur_d) begin
      bus.dir = d; cur_d = d;
      wait_pattern(exp_gates(cur_s, cur_d), "walk_dir");
    end
    for (int i = 0; i < 10; i++) begin
      cur_s = ($urandom_range(0, 1) == 1) ? (cur_s + 1) % 6 : (cur_s + 5) % 6;
      hold($urandom_range(20, 400));
      hall_step(hall_of(cur_s), "walk_step");
      wait_pattern(exp_gates(cur_s, cur_d), "walk_step");
    end
  endtask

  task automatic test_stall();
    int n;
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    wait_pattern(exp_gates(cur_s, cur_d), "stall_entry");
    n = 0;
    do begin tick(); n++; end while (cur_gates() !== 6'b0 && n < 2 * SC);
    checks++;
    if (n != SC) begin
      failures++;
      $display("FAIL stall_time cycles=%0d required=%0d", n, SC);
    end
    checks++;
    if (bus.stalled !== 1'b1) begin
      failures++;
      $display("FAIL stall_flag got=%b required=1", bus.stalled);
    end
    bus.enable = 1'b0;
    tick();
    checks++;
    if (bus.stalled !== 1'b0) begin
      failures++;
      $display("FAIL stall_clear got=%b required=0", bus.stalled);
    end
    bus.enable = 1'b1;
    wait_pattern(exp_gates(cur_s, cur_d), "stall_resume");
  endtask

  initial begin
    test_reset();
    test_startup();
    test_forward_steps();
    test_dir_toggle();
    test_pwm();
    test_glitch_and_invalid();
    test_fault();
    test_random_walk();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
